// File: rtl/ecm_output_combiner.sv
// ECM channel output combiner: per-channel {mode, gain} table selects DDS, DRFM,
// complex mixer or average, then applies rounded gain and saturation over a 4-cycle pipeline.
module ecm_output_combiner #(
  parameter int NUM_CHANNELS        = 16,
  parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
  parameter int DDS_WIDTH           = 18,
  parameter int DRFM_WIDTH          = 16,
  parameter int OUTPUT_WIDTH        = 16,
  parameter int GAIN_WIDTH          = 8,
  parameter int ENABLE_DDS          = 1,
  parameter int ENABLE_DRFM         = 1
) (
  input  logic                                  Clk,
  input  logic                                  Rst,
  input  logic                                  Dwell_active_transmit,
  input  logic                                  Ctrl_valid,
  input  logic [CHANNEL_INDEX_WIDTH-1:0]        Ctrl_channel,
  input  logic [2:0]                            Ctrl_mode,
  input  logic [GAIN_WIDTH-1:0]                 Ctrl_gain,
  input  logic                                  Dds_valid,
  input  logic                                  Dds_last,
  input  logic [CHANNEL_INDEX_WIDTH-1:0]        Dds_index,
  input  logic signed [DDS_WIDTH-1:0]           Dds_i,
  input  logic signed [DDS_WIDTH-1:0]           Dds_q,
  input  logic                                  Drfm_valid,
  input  logic                                  Drfm_last,
  input  logic [CHANNEL_INDEX_WIDTH-1:0]        Drfm_index,
  input  logic signed [DRFM_WIDTH-1:0]          Drfm_i,
  input  logic signed [DRFM_WIDTH-1:0]          Drfm_q,
  output logic                                  Synth_valid,
  output logic                                  Synth_last,
  output logic [CHANNEL_INDEX_WIDTH-1:0]        Synth_index,
  output logic signed [OUTPUT_WIDTH-1:0]        Synth_i,
  output logic signed [OUTPUT_WIDTH-1:0]        Synth_q,
  output logic [CHANNEL_INDEX_WIDTH:0]          Active_channel_count,
  output logic                                  Saturation,
  output logic                                  Error_dds_drfm_sync
);
  localparam int CW  = CHANNEL_INDEX_WIDTH;
  localparam int OW  = OUTPUT_WIDTH;
  localparam int DW  = DDS_WIDTH;
  localparam int RW  = DRFM_WIDTH;
  localparam int GW  = GAIN_WIDTH;
  localparam int PW  = DW + RW;
  localparam int MW  = PW + 1;
  localparam int GPW = OW + GW + 1;
  localparam int YW  = OW + 2;
  localparam logic [GW-1:0]         GAIN_UNITY = GW'(1) << (GW - 1);
  localparam logic signed [GPW-1:0] RND        = GPW'(1) << (GW - 2);
  localparam logic signed [YW-1:0]  SMAX       = YW'({1'b0, {(OW-1){1'b1}}});
  localparam logic signed [YW-1:0]  SMIN       = ~SMAX;

  function automatic logic is_active(input logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd4);
  endfunction

  function automatic logic signed [YW-1:0] round_gain(input logic signed [GPW-1:0] p);
    return YW'((p + RND) >>> (GW - 1));
  endfunction

  function automatic logic clipped(input logic signed [YW-1:0] y);
    return (y > SMAX) || (y < SMIN);
  endfunction

  function automatic logic signed [OW-1:0] saturate(input logic signed [YW-1:0] y);
    if (y > SMAX) return OW'(SMAX);
    if (y < SMIN) return OW'(SMIN);
    return OW'(y);
  endfunction

  // Control table and active-channel count
  logic [2:0]    mode_q [NUM_CHANNELS];
  logic [2:0]    mode_d [NUM_CHANNELS];
  logic [GW-1:0] gain_q [NUM_CHANNELS];
  logic [GW-1:0] gain_d [NUM_CHANNELS];
  logic [CW:0]   count_q, count_d;

  always_comb begin
    mode_d  = mode_q;
    gain_d  = gain_q;
    count_d = count_q;
    if (Ctrl_valid) begin
      mode_d[Ctrl_channel] = Ctrl_mode;
      gain_d[Ctrl_channel] = Ctrl_gain;
      count_d = count_q + (CW+1)'(is_active(Ctrl_mode)) - (CW+1)'(is_active(mode_q[Ctrl_channel]));
    end
  end

  // Stage p0: beat acceptance, alignment check, table lookup
  logic                 acc, err_d, err_q, vld_p0_q;
  logic [CW-1:0]        ch, idx_p0_q;
  logic                 last_d, last_p0_q, tx_p0_q;
  logic [2:0]           mode_p0_q;
  logic [GW-1:0]        gain_p0_q;
  logic signed [DW-1:0] di_d, dq_d, di_p0_q, dq_p0_q;
  logic signed [RW-1:0] ri_d, rq_d, ri_p0_q, rq_p0_q;

  always_comb begin
    acc   = 1'b0;
    err_d = 1'b0;
    if (ENABLE_DDS != 0 && ENABLE_DRFM != 0) begin
      acc   = Dds_valid && Drfm_valid && (Dds_index == Drfm_index);
      err_d = (Dds_valid != Drfm_valid) || (Dds_valid && Drfm_valid && (Dds_index != Drfm_index));
    end else if (ENABLE_DDS != 0) begin
      acc = Dds_valid;
    end else if (ENABLE_DRFM != 0) begin
      acc = Drfm_valid;
    end
    ch     = (ENABLE_DDS != 0) ? Dds_index : Drfm_index;
    last_d = (ENABLE_DDS != 0 && ENABLE_DRFM != 0) ? (Dds_last | Drfm_last) :
             (ENABLE_DDS != 0) ? Dds_last : Drfm_last;
    di_d   = (ENABLE_DDS != 0)  ? Dds_i  : '0;
    dq_d   = (ENABLE_DDS != 0)  ? Dds_q  : '0;
    ri_d   = (ENABLE_DRFM != 0) ? Drfm_i : '0;
    rq_d   = (ENABLE_DRFM != 0) ? Drfm_q : '0;
  end

  // Stage p1: mixer partial products and non-mixer operand selection
  logic                 vld_p1_q, last_p1_q, tx_p1_q;
  logic [CW-1:0]        idx_p1_q;
  logic [2:0]           mode_p1_q;
  logic [GW-1:0]        gain_p1_q;
  logic signed [OW-1:0] d_i, d_q, r_i, r_q, xs_i_d, xs_q_d, xs_i_p1_q, xs_q_p1_q;
  logic signed [OW:0]   sum_i, sum_q;
  logic signed [PW-1:0] pii_d, pqq_d, piq_d, pqi_d, pii_p1_q, pqq_p1_q, piq_p1_q, pqi_p1_q;

  always_comb begin
    d_i    = OW'(di_p0_q >>> (DW - OW));
    d_q    = OW'(dq_p0_q >>> (DW - OW));
    r_i    = OW'(ri_p0_q >>> (RW - OW));
    r_q    = OW'(rq_p0_q >>> (RW - OW));
    sum_i  = (OW+1)'(d_i) + (OW+1)'(r_i);
    sum_q  = (OW+1)'(d_q) + (OW+1)'(r_q);
    pii_d  = PW'(di_p0_q) * PW'(ri_p0_q);
    pqq_d  = PW'(dq_p0_q) * PW'(rq_p0_q);
    piq_d  = PW'(di_p0_q) * PW'(rq_p0_q);
    pqi_d  = PW'(dq_p0_q) * PW'(ri_p0_q);
    xs_i_d = '0;
    xs_q_d = '0;
    case (mode_p0_q)
      3'd1:    begin xs_i_d = d_i;                 xs_q_d = d_q;                 end
      3'd2:    begin xs_i_d = r_i;                 xs_q_d = r_q;                 end
      3'd4:    begin xs_i_d = OW'(sum_i >>> 1);    xs_q_d = OW'(sum_q >>> 1);    end
      default: begin xs_i_d = '0;                  xs_q_d = '0;                  end
    endcase
  end

  // Stage p2: final operand and gain product
  logic                  vld_p2_q, last_p2_q, tx_p2_q;
  logic [CW-1:0]         idx_p2_q;
  logic signed [MW-1:0]  mix_i, mix_q;
  logic signed [OW-1:0]  x_i, x_q;
  logic signed [GPW-1:0] g_ext, prod_i_d, prod_q_d, prod_i_p2_q, prod_q_p2_q;

  always_comb begin
    mix_i    = MW'(pii_p1_q) - MW'(pqq_p1_q);
    mix_q    = MW'(piq_p1_q) + MW'(pqi_p1_q);
    x_i      = (mode_p1_q == 3'd3) ? OW'(mix_i >>> (MW - OW)) : xs_i_p1_q;
    x_q      = (mode_p1_q == 3'd3) ? OW'(mix_q >>> (MW - OW)) : xs_q_p1_q;
    g_ext    = GPW'($signed({1'b0, gain_p1_q}));
    prod_i_d = GPW'(x_i) * g_ext;
    prod_q_d = GPW'(x_q) * g_ext;
  end

  // Output stage: round, saturate, transmit gating
  logic                 synth_valid_q, synth_valid_d, synth_last_q, synth_last_d;
  logic [CW-1:0]        synth_index_q, synth_index_d;
  logic signed [OW-1:0] synth_i_q, synth_i_d, synth_q_q, synth_q_d;
  logic                 saturation_q, saturation_d;
  logic signed [YW-1:0] y_i, y_q;

  always_comb begin
    y_i           = round_gain(prod_i_p2_q);
    y_q           = round_gain(prod_q_p2_q);
    synth_valid_d = vld_p2_q;
    synth_last_d  = vld_p2_q && last_p2_q;
    synth_index_d = synth_index_q;
    synth_i_d     = synth_i_q;
    synth_q_d     = synth_q_q;
    saturation_d  = vld_p2_q && tx_p2_q && (clipped(y_i) || clipped(y_q));
    if (vld_p2_q) begin
      synth_index_d = idx_p2_q;
      synth_i_d     = tx_p2_q ? saturate(y_i) : '0;
      synth_q_d     = tx_p2_q ? saturate(y_q) : '0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mode_q        <= '{default: 3'd0};
      gain_q        <= '{default: GAIN_UNITY};
      count_q       <= '0;
      vld_p0_q      <= 1'b0;
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      err_q         <= 1'b0;
      synth_valid_q <= 1'b0;
      synth_last_q  <= 1'b0;
      synth_index_q <= '0;
      synth_i_q     <= '0;
      synth_q_q     <= '0;
      saturation_q  <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      gain_q        <= gain_d;
      count_q       <= count_d;
      vld_p0_q      <= acc;
      vld_p1_q      <= vld_p0_q;
      vld_p2_q      <= vld_p1_q;
      err_q         <= err_d;
      synth_valid_q <= synth_valid_d;
      synth_last_q  <= synth_last_d;
      synth_index_q <= synth_index_d;
      synth_i_q     <= synth_i_d;
      synth_q_q     <= synth_q_d;
      saturation_q  <= saturation_d;
    end
  end

  always_ff @(posedge Clk) begin
    idx_p0_q    <= ch;
    last_p0_q   <= last_d;
    tx_p0_q     <= Dwell_active_transmit;
    mode_p0_q   <= mode_q[ch];
    gain_p0_q   <= gain_q[ch];
    di_p0_q     <= di_d;
    dq_p0_q     <= dq_d;
    ri_p0_q     <= ri_d;
    rq_p0_q     <= rq_d;
    idx_p1_q    <= idx_p0_q;
    last_p1_q   <= last_p0_q;
    tx_p1_q     <= tx_p0_q;
    mode_p1_q   <= mode_p0_q;
    gain_p1_q   <= gain_p0_q;
    xs_i_p1_q   <= xs_i_d;
    xs_q_p1_q   <= xs_q_d;
    pii_p1_q    <= pii_d;
    pqq_p1_q    <= pqq_d;
    piq_p1_q    <= piq_d;
    pqi_p1_q    <= pqi_d;
    idx_p2_q    <= idx_p1_q;
    last_p2_q   <= last_p1_q;
    tx_p2_q     <= tx_p1_q;
    prod_i_p2_q <= prod_i_d;
    prod_q_p2_q <= prod_q_d;
  end

  assign Synth_valid          = synth_valid_q;
  assign Synth_last           = synth_last_q;
  assign Synth_index          = synth_index_q;
  assign Synth_i              = synth_i_q;
  assign Synth_q              = synth_q_q;
  assign Saturation           = saturation_q;
  assign Error_dds_drfm_sync  = err_q;
  assign Active_channel_count = count_q;
endmodule

// File: tb/tb_ecm_output_combiner.sv
// Directed bench for ecm_output_combiner: hand-computed vectors for each mode,
// rounding, saturation, gating, source misalignment, table timing and reset.
module tb_ecm_output_combiner;
  logic               Clk = 1'b0;
  logic               Rst;
  logic               Dwell_active_transmit;
  logic               Ctrl_valid;
  logic [3:0]         Ctrl_channel;
  logic [2:0]         Ctrl_mode;
  logic [7:0]         Ctrl_gain;
  logic               Dds_valid, Dds_last;
  logic [3:0]         Dds_index;
  logic signed [17:0] Dds_i, Dds_q;
  logic               Drfm_valid, Drfm_last;
  logic [3:0]         Drfm_index;
  logic signed [15:0] Drfm_i, Drfm_q;
  logic               Synth_valid, Synth_last;
  logic [3:0]         Synth_index;
  logic signed [15:0] Synth_i, Synth_q;
  logic [4:0]         Active_channel_count;
  logic               Saturation;
  logic               Error_dds_drfm_sync;

  int errors = 0;
  int checks = 0;

  ecm_output_combiner dut (
    .Clk(Clk), .Rst(Rst), .Dwell_active_transmit(Dwell_active_transmit),
    .Ctrl_valid(Ctrl_valid), .Ctrl_channel(Ctrl_channel), .Ctrl_mode(Ctrl_mode), .Ctrl_gain(Ctrl_gain),
    .Dds_valid(Dds_valid), .Dds_last(Dds_last), .Dds_index(Dds_index), .Dds_i(Dds_i), .Dds_q(Dds_q),
    .Drfm_valid(Drfm_valid), .Drfm_last(Drfm_last), .Drfm_index(Drfm_index), .Drfm_i(Drfm_i), .Drfm_q(Drfm_q),
    .Synth_valid(Synth_valid), .Synth_last(Synth_last), .Synth_index(Synth_index),
    .Synth_i(Synth_i), .Synth_q(Synth_q), .Active_channel_count(Active_channel_count),
    .Saturation(Saturation), .Error_dds_drfm_sync(Error_dds_drfm_sync)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [3:0] ch, input logic [2:0] mode, input logic [7:0] gain);
    Ctrl_valid = 1'b1; Ctrl_channel = ch; Ctrl_mode = mode; Ctrl_gain = gain;
  endtask

  task automatic drive_beat(input logic [3:0] ch, input logic signed [17:0] di, input logic signed [17:0] dq,
                            input logic signed [15:0] ri, input logic signed [15:0] rq, input logic last);
    Dds_valid = 1'b1;  Dds_index = ch;  Dds_i = di;  Dds_q = dq;  Dds_last = last;
    Drfm_valid = 1'b1; Drfm_index = ch; Drfm_i = ri; Drfm_q = rq; Drfm_last = last;
  endtask

  task automatic clr_inputs();
    Ctrl_valid = 1'b0; Dds_valid = 1'b0; Drfm_valid = 1'b0; Dds_last = 1'b0; Drfm_last = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick(); tick();
    checks++; if (Synth_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", Synth_valid); end
    checks++; if (Synth_i !== 16'sd0) begin errors++; $display("FAIL reset_i: got %0d want 0", Synth_i); end
    checks++; if (Active_channel_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", Active_channel_count); end
    checks++; if (Error_dds_drfm_sync !== 1'b0 || Saturation !== 1'b0) begin errors++; $display("FAIL reset_flags: got err=%b sat=%b want 0 0", Error_dds_drfm_sync, Saturation); end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_dds();
    set_ctrl(4'd2, 3'd1, 8'd128);
    tick(); clr_inputs();
    checks++; if (Active_channel_count !== 5'd1) begin errors++; $display("FAIL dds_count: got %0d want 1", Active_channel_count); end
    drive_beat(4'd2, 18'sh00100, -18'sd4, 16'sd0, 16'sd0, 1'b0);
    tick(); clr_inputs();
    tick(); tick();
    checks++; if (Synth_valid !== 1'b0) begin errors++; $display("FAIL dds_early: got valid=%b want 0 at cycle 3", Synth_valid); end
    tick();
    checks++; if (Synth_valid !== 1'b1 || Synth_index !== 4'd2) begin errors++; $display("FAIL dds_valid: got v=%b idx=%0d want 1 2", Synth_valid, Synth_index); end
    checks++; if (Synth_i !== 16'sd64 || Synth_q !== -16'sd1) begin errors++; $display("FAIL dds_data: got %0d,%0d want 64,-1", Synth_i, Synth_q); end
    checks++; if (Saturation !== 1'b0) begin errors++; $display("FAIL dds_sat: got %b want 0", Saturation); end
  endtask

  task automatic test_mixer();
    set_ctrl(4'd5, 3'd3, 8'd128);
    tick(); clr_inputs();
    checks++; if (Active_channel_count !== 5'd2) begin errors++; $display("FAIL mix_count: got %0d want 2", Active_channel_count); end
    drive_beat(4'd5, 18'sd65536, 18'sd0, 16'sd16384, 16'sd0, 1'b0);
    tick(); clr_inputs();
    tick(); tick(); tick();
    checks++; if (Synth_valid !== 1'b1 || Synth_i !== 16'sd2048 || Synth_q !== 16'sd0) begin errors++; $display("FAIL mixer: got v=%b %0d,%0d want 1 2048,0", Synth_valid, Synth_i, Synth_q); end
  endtask

  task automatic test_drfm_sat();
    set_ctrl(4'd7, 3'd2, 8'd255);
    tick(); clr_inputs();
    checks++; if (Active_channel_count !== 5'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", Active_channel_count); end
    drive_beat(4'd7, 18'sd0, 18'sd0, 16'sd32767, 16'sh8000, 1'b1);
    tick(); clr_inputs();
    tick(); tick(); tick();
    checks++; if (Synth_i !== 16'sd32767 || Synth_q !== 16'sh8000) begin errors++; $display("FAIL sat_data: got %0d,%0d want 32767,-32768", Synth_i, Synth_q); end
    checks++; if (Saturation !== 1'b1 || Synth_last !== 1'b1) begin errors++; $display("FAIL sat_pulse: got sat=%b last=%b want 1 1", Saturation, Synth_last); end
    tick();
    checks++; if (Saturation !== 1'b0 || Synth_valid !== 1'b0) begin errors++; $display("FAIL sat_once: got sat=%b v=%b want 0 0", Saturation, Synth_valid); end
  endtask

  task automatic test_sync_error();
    Dds_valid = 1'b1; Dds_index = 4'd3; Dds_i = 18'sh400; Dds_q = 18'sd0;
    Drfm_valid = 1'b1; Drfm_index = 4'd4; Drfm_i = 16'sd0; Drfm_q = 16'sd0;
    tick();
    checks++; if (Error_dds_drfm_sync !== 1'b1) begin errors++; $display("FAIL sync_err: got %b want 1", Error_dds_drfm_sync); end
    drive_beat(4'd2, 18'sh400, 18'sd0, 16'sd0, 16'sd0, 1'b0);
    tick(); clr_inputs();
    checks++; if (Error_dds_drfm_sync !== 1'b0) begin errors++; $display("FAIL sync_err_len: got %b want 0", Error_dds_drfm_sync); end
    tick(); tick();
    checks++; if (Synth_valid !== 1'b0) begin errors++; $display("FAIL sync_drop: got valid=%b want 0", Synth_valid); end
    tick();
    checks++; if (Synth_valid !== 1'b1 || Synth_index !== 4'd2 || Synth_i !== 16'sd256) begin errors++; $display("FAIL sync_next: got v=%b idx=%0d i=%0d want 1 2 256", Synth_valid, Synth_index, Synth_i); end
    Dds_valid = 1'b1; Dds_index = 4'd2;
    tick(); clr_inputs();
    checks++; if (Error_dds_drfm_sync !== 1'b1) begin errors++; $display("FAIL lone_err: got %b want 1", Error_dds_drfm_sync); end
    tick(); tick(); tick();
    checks++; if (Synth_valid !== 1'b0) begin errors++; $display("FAIL lone_drop: got valid=%b want 0", Synth_valid); end
  endtask

  task automatic test_write_collision();
    set_ctrl(4'd1, 3'd4, 8'd128);
    drive_beat(4'd1, 18'sh04000, -18'sd2048, 16'sd1000, 16'sd100, 1'b0);
    tick(); Ctrl_valid = 1'b0;
    checks++; if (Active_channel_count !== 5'd4) begin errors++; $display("FAIL coll_count: got %0d want 4", Active_channel_count); end
    tick(); clr_inputs();
    tick(); tick();
    checks++; if (Synth_valid !== 1'b1 || Synth_index !== 4'd1 || Synth_i !== 16'sd0 || Synth_q !== 16'sd0) begin errors++; $display("FAIL coll_old: got v=%b idx=%0d %0d,%0d want 1 1 0,0", Synth_valid, Synth_index, Synth_i, Synth_q); end
    tick();
    checks++; if (Synth_valid !== 1'b1 || Synth_i !== 16'sd2548 || Synth_q !== -16'sd206) begin errors++; $display("FAIL coll_new: got v=%b %0d,%0d want 1 2548,-206", Synth_valid, Synth_i, Synth_q); end
  endtask

  task automatic test_rounding();
    set_ctrl(4'd2, 3'd1, 8'd64);
    tick(); clr_inputs();
    drive_beat(4'd2, 18'sd12, -18'sd12, 16'sd0, 16'sd0, 1'b0);
    tick(); clr_inputs();
    tick(); tick(); tick();
    checks++; if (Synth_i !== 16'sd2 || Synth_q !== -16'sd1) begin errors++; $display("FAIL round_half_up: got %0d,%0d want 2,-1", Synth_i, Synth_q); end
  endtask

  task automatic test_back_to_back();
    drive_beat(4'd2, 18'sd8, 18'sd0, 16'sd0, 16'sd0, 1'b0);  tick();
    drive_beat(4'd2, 18'sd16, 18'sd0, 16'sd0, 16'sd0, 1'b0); tick();
    drive_beat(4'd2, 18'sd24, 18'sd0, 16'sd0, 16'sd0, 1'b1); tick();
    clr_inputs();
    tick();
    checks++; if (Synth_valid !== 1'b1 || Synth_i !== 16'sd1 || Synth_last !== 1'b0) begin errors++; $display("FAIL b2b_0: got v=%b i=%0d last=%b want 1 1 0", Synth_valid, Synth_i, Synth_last); end
    tick();
    checks++; if (Synth_valid !== 1'b1 || Synth_i !== 16'sd2) begin errors++; $display("FAIL b2b_1: got v=%b i=%0d want 1 2", Synth_valid, Synth_i); end
    tick();
    checks++; if (Synth_valid !== 1'b1 || Synth_i !== 16'sd3 || Synth_last !== 1'b1) begin errors++; $display("FAIL b2b_2: got v=%b i=%0d last=%b want 1 3 1", Synth_valid, Synth_i, Synth_last); end
  endtask

  task automatic test_tx_gate();
    Dwell_active_transmit = 1'b0;
    drive_beat(4'd7, 18'sd0, 18'sd0, 16'sd32767, 16'sh8000, 1'b0);
    tick(); clr_inputs(); Dwell_active_transmit = 1'b1;
    tick(); tick(); tick();
    checks++; if (Synth_valid !== 1'b1 || Synth_i !== 16'sd0 || Synth_q !== 16'sd0) begin errors++; $display("FAIL tx_gate: got v=%b %0d,%0d want 1 0,0", Synth_valid, Synth_i, Synth_q); end
    checks++; if (Saturation !== 1'b0) begin errors++; $display("FAIL tx_gate_sat: got %b want 0", Saturation); end
  endtask

  task automatic test_reset_midframe();
    int stale;
    set_ctrl(4'd6, 3'd1, 8'd128);
    tick(); clr_inputs();
    checks++; if (Active_channel_count !== 5'd5) begin errors++; $display("FAIL mid_count_pre: got %0d want 5", Active_channel_count); end
    for (int b = 0; b < 10; b++) begin
      drive_beat(4'(b), 18'sh400, 18'sd0, 16'sd0, 16'sd0, 1'b0);
      tick();
    end
    drive_beat(4'd10, 18'sh400, 18'sd0, 16'sd0, 16'sd0, 1'b0);
    checks++; if (Synth_valid !== 1'b1 || Synth_index !== 4'd6 || Synth_i !== 16'sd256) begin errors++; $display("FAIL mid_pre: got v=%b idx=%0d i=%0d want 1 6 256", Synth_valid, Synth_index, Synth_i); end
    Rst = 1'b1;
    #1;
    checks++; if (Synth_valid !== 1'b0 || Synth_i !== 16'sd0 || Synth_index !== 4'd0) begin errors++; $display("FAIL mid_async: got v=%b i=%0d idx=%0d want 0 0 0", Synth_valid, Synth_i, Synth_index); end
    checks++; if (Active_channel_count !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", Active_channel_count); end
    tick(); tick();
    clr_inputs();
    Rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (Synth_valid === 1'b1) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale: got %0d stale beats want 0", stale); end
    drive_beat(4'd6, 18'sh400, 18'sh400, 16'sd0, 16'sd0, 1'b0);
    tick(); clr_inputs();
    tick(); tick(); tick();
    checks++; if (Synth_valid !== 1'b1 || Synth_i !== 16'sd0 || Synth_q !== 16'sd0) begin errors++; $display("FAIL mid_table_off: got v=%b %0d,%0d want 1 0,0", Synth_valid, Synth_i, Synth_q); end
    checks++; if (Active_channel_count !== 5'd0) begin errors++; $display("FAIL mid_count_post: got %0d want 0", Active_channel_count); end
  endtask

  initial begin
    Rst = 1'b1; Dwell_active_transmit = 1'b1;
    Ctrl_channel = '0; Ctrl_mode = '0; Ctrl_gain = '0;
    Dds_index = '0; Dds_i = '0; Dds_q = '0;
    Drfm_index = '0; Drfm_i = '0; Drfm_q = '0;
    clr_inputs();
    test_reset();
    test_dds();
    test_mixer();
    test_drfm_sat();
    test_sync_error();
    test_write_collision();
    test_rounding();
    test_back_to_back();
    test_tx_gate();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ecm_output_combiner.md
ECM_OUTPUT_COMBINER -- requirements
Module: ecm_output_combiner

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 16: number of channelizer channels, power of 2, 2..64.
REQ-002 SHALL have parameter CHANNEL_INDEX_WIDTH, default clog2(NUM_CHANNELS): width of the channel index.
REQ-003 SHALL have parameters DDS_WIDTH, default 18, DRFM_WIDTH, default 16, and OUTPUT_WIDTH, default 16: I/Q sample widths, with DDS_WIDTH and DRFM_WIDTH each >= OUTPUT_WIDTH.
REQ-004 SHALL have parameter GAIN_WIDTH, default 8: unsigned per-channel gain, unity = 2^(GAIN_WIDTH-1).
REQ-005 SHALL have parameters ENABLE_DDS, default 1, and ENABLE_DRFM, default 1: when a parameter is 0, that source reads as zero and its ports are ignored.
REQ-006 SHALL have ports, one per line (name direction width meaning):
 Clk  in  1  sole clock
 Rst  in  1  asynchronous, active-high reset
 Dwell_active_transmit  in  1  transmit window open
 Ctrl_valid  in  1  control table write strobe
 Ctrl_channel  in  CHANNEL_INDEX_WIDTH  channel to write
 Ctrl_mode  in  3  0 off, 1 dds, 2 drfm, 3 mixer, 4 sum, 5-7 off
 Ctrl_gain  in  GAIN_WIDTH  channel gain
 Dds_valid / Dds_last  in  1 / 1  DDS beat strobe / last channel of frame
 Dds_index  in  CHANNEL_INDEX_WIDTH  DDS channel
 Dds_i, Dds_q  in  DDS_WIDTH each  signed DDS sample
 Drfm_valid / Drfm_last  in  1 / 1  DRFM beat strobe / last
 Drfm_index  in  CHANNEL_INDEX_WIDTH  DRFM channel
 Drfm_i, Drfm_q  in  DRFM_WIDTH each  signed DRFM sample
 Synth_valid / Synth_last  out  1 / 1  output beat strobe / last
 Synth_index  out  CHANNEL_INDEX_WIDTH  output channel
 Synth_i, Synth_q  out  OUTPUT_WIDTH each  signed output sample
 Active_channel_count  out  CHANNEL_INDEX_WIDTH+1  channels with mode 1-4
 Saturation  out  1  pulse: a beat was clipped
 Error_dds_drfm_sync  out  1  pulse: sources misaligned

Function
REQ-007 SHALL hold a register-based control table of NUM_CHANNELS entries {mode, gain}; a write at cycle t SHALL affect beats sampled at t+1 onward and SHALL NOT affect beats sampled at t.
REQ-008 SHALL update Active_channel_count one cycle after each table write.
REQ-009 SHALL treat a beat as valid in the cycle the enabled valids are asserted. With both sources enabled, Dds_valid != Drfm_valid, or both valid with Dds_index != Drfm_index, SHALL drop the beat, produce no output, and pulse Error_dds_drfm_sync one cycle later.
REQ-010 SHALL produce Synth_valid exactly 4 cycles after each accepted beat, with no bubbles, at up to one beat per cycle, and with index and last passed through unchanged.
REQ-011 SHALL align each source to OUTPUT_WIDTH by taking its top OUTPUT_WIDTH bits (truncation): d = Dds[DDS_WIDTH-1 -: OUTPUT_WIDTH], r = Drfm[DRFM_WIDTH-1 -: OUTPUT_WIDTH].
REQ-012 SHALL select x per mode:
 - dds: x = d
 - drfm: x = r
 - mixer: full complex product (I = Di*Ri - Dq*Rq; Q = Di*Rq + Dq*Ri) at DDS_WIDTH+DRFM_WIDTH+1 bits, taking bits [DDS_WIDTH+DRFM_WIDTH -: OUTPUT_WIDTH]
 - sum: x = (d + r) >>> 1 at OUTPUT_WIDTH+1 bits
 - off: x = 0
REQ-013 SHALL compute y = (x*gain + 2^(GAIN_WIDTH-2)) >>> (GAIN_WIDTH-1), giving round-half-up for any gain.
REQ-014 SHALL saturate y to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1], independently on I and Q.
REQ-015 SHALL pulse Saturation coincident with the Synth_valid of any beat in which I or Q was clipped.
REQ-016 SHALL force Synth_i/Synth_q to 0 while Dwell_active_transmit was low at beat acceptance; the beat still emerges with valid asserted and SHALL NOT assert Saturation.

Reset
REQ-017 Rst SHALL asynchronously clear:
 - all pipeline valids
 - Synth_valid, Synth_last, Saturation, Error_dds_drfm_sync to 0
 - Synth_index, Synth_i, Synth_q to 0
 - every table entry to mode off, gain unity
 - Active_channel_count to 0
REQ-018 Beats in flight when Rst asserts SHALL be discarded and never emerge after Rst deasserts.

Verification
REQ-019 Defaults; ch 2 = dds, gain 128; Dds_i = 0x00100, Dds_q = -4 -> 4 cycles later: Synth_index = 2, I = 64, Q = -1, Saturation = 0.
REQ-020 Ch 5 = mixer, gain 128; Dds = (65536, 0), Drfm = (16384, 0) -> I = 2048, Q = 0.
REQ-021 Ch 7 = drfm, gain 255; Drfm_i = 32767, Drfm_q = -32768 -> I = 32767, Q = -32768, Saturation pulses once.
REQ-022 Dds_valid with index 3 while Drfm_valid has index 4 -> no Synth_valid for that beat; Error_dds_drfm_sync high exactly one cycle; the following aligned beat passes normally.
REQ-023 Write ch 1 mode sum in the same cycle as a ch 1 beat -> that beat uses the old mode (off -> 0); the next ch 1 beat uses sum; Active_channel_count increments by 1.
REQ-024 Continuous 16-beat frame, Rst asserted at beat 10 -> outputs drop to 0 immediately; after release, no stale beats, all table entries off, count = 0.
